// File: rtl/rv32_mod_data_ram_responder.sv
// rv32_mod_data_ram_responder
//   Default data memory on the hart data bus. It latches one request, waits
//   WAIT_STATES cycles, and then completes it with a one-cycle data_ack, or
//   with data_err if the request is rejected. Stores merge per byte lane.
//   Loads return the whole addressed word. Every output is registered.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset (asserted at 0)
//   data_req     request level, held by the initiator until it sees ack/err
//   data_wr      1 = store, 0 = load
//   data_be      byte-lane enables
//   data_addr    byte address; bits [1:0] are ignored
//   data_data_i  lane-aligned store data
//   data_data_o  load data; nonzero only in the ack cycle of a load
//   data_ack     one-cycle successful completion
//   data_err     one-cycle rejected completion
module rv32_mod_data_ram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_data_i,
    output logic [31:0] data_data_o,
    output logic        data_ack,
    output logic        data_err
);

    localparam int         IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;

    // Request fields, captured in IDLE
    logic          cap_wr;
    logic [3:0]    cap_be;
    logic [IW-1:0] cap_idx;
    logic [31:0]   cap_data;
    logic          cap_rej;

    logic [31:0]   mem [DEPTH_WORDS];

    // Decode of the live request
    logic [31:0]   addr_w;
    logic [31:0]   off;
    logic          in_rej;

    // The access being completed. When WAIT_STATES is 0, RESP is entered on
    // the same edge that captures the request, so the live inputs are used.
    // Otherwise the captured copy is used.
    logic          acc_wr;
    logic [3:0]    acc_be;
    logic [IW-1:0] acc_idx;
    logic [31:0]   acc_data;
    logic          acc_rej;
    logic          enter_resp;

    always_comb begin
        addr_w = {data_addr[31:2], 2'b00};
        off    = addr_w - BASE_ADDR;
        // The below-base test keeps a wrapped offset from looking in range.
        in_rej = (data_be == 4'b0000) || (addr_w < BASE_ADDR) ||
                 ({2'b00, off[31:2]} >= 32'(DEPTH_WORDS));
    end

    always_comb begin
        if (state == ST_IDLE) begin
            acc_wr   = data_wr;
            acc_be   = data_be;
            acc_idx  = off[IW+1:2];
            acc_data = data_data_i;
            acc_rej  = in_rej;
        end else begin
            acc_wr   = cap_wr;
            acc_be   = cap_be;
            acc_idx  = cap_idx;
            acc_data = cap_data;
            acc_rej  = cap_rej;
        end
        enter_resp = ((state == ST_IDLE) && data_req && (WS == 4'd0)) ||
                     ((state == ST_WAIT) && (cnt == 4'd1));
    end

    // The address bits that are not decoded are collected here on purpose.
    logic unused_bits;
    assign unused_bits = ^{data_addr[1:0], off};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            cap_wr      <= 1'b0;
            cap_be      <= 4'b0000;
            cap_idx     <= '0;
            cap_data    <= 32'h0;
            cap_rej     <= 1'b0;
            data_ack    <= 1'b0;
            data_err    <= 1'b0;
            data_data_o <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_req) begin
                        cap_wr   <= data_wr;
                        cap_be   <= data_be;
                        cap_idx  <= off[IW+1:2];
                        cap_data <= data_data_i;
                        cap_rej  <= in_rej;
                        cnt      <= WS;
                        state    <= (WS == 4'd0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            data_ack    <= enter_resp && !acc_rej;
            data_err    <= enter_resp && acc_rej;
            data_data_o <= (enter_resp && !acc_rej && !acc_wr) ? mem[acc_idx] : 32'h0;
        end
    end

    // Memory has no reset. Gating the write with reset keeps an aborted
    // access from writing.
    always_ff @(posedge clk) begin
        if (enter_resp && reset && acc_wr && !acc_rej) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_rv32_mod_data_ram_responder.sv
module tb_rv32_mod_data_ram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, wr;
    logic [3:0]  be;
    logic [31:0] addr, wdata;

    logic        d1_ack, d1_err, d0_ack, d0_err, d15_ack, d15_err;
    logic [31:0] d1_dout, d0_dout, d15_dout;

    int n_cmp = 0;
    int n_bad = 0;

    int          lat;
    logic        r_ack, r_err, n_resp;
    logic [31:0] r_dout, n_dout;

    always #5 clk = ~clk;

    rv32_mod_data_ram_responder #(.BASE_ADDR(32'h1000), .DEPTH_WORDS(256), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset(rst_n), .data_req(req), .data_wr(wr), .data_be(be),
        .data_addr(addr), .data_data_i(wdata), .data_data_o(d1_dout),
        .data_ack(d1_ack), .data_err(d1_err));

    rv32_mod_data_ram_responder #(.BASE_ADDR(32'h1000), .DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst_n), .data_req(req), .data_wr(wr), .data_be(be),
        .data_addr(addr), .data_data_i(wdata), .data_data_o(d0_dout),
        .data_ack(d0_ack), .data_err(d0_err));

    rv32_mod_data_ram_responder #(.BASE_ADDR(32'h1000), .DEPTH_WORDS(256), .WAIT_STATES(15)) dut15 (
        .clk(clk), .reset(rst_n), .data_req(req), .data_wr(wr), .data_be(be),
        .data_addr(addr), .data_data_i(wdata), .data_data_o(d15_dout),
        .data_ack(d15_ack), .data_err(d15_err));

    // Issues one access to dut1 and waits up to 40 cycles for its response.
    // The caller must be at a negedge. lat counts posedges from capture
    // (1 = the capture edge). The next cycle's response and data are also
    // returned.
    task automatic access(input logic w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] d);
        req = 1'b1; wr = w; be = b; addr = a; wdata = d;
        lat = -1; r_ack = 1'b0; r_err = 1'b0; r_dout = 32'h0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (d1_ack || d1_err) begin
                lat = k; r_ack = d1_ack; r_err = d1_err; r_dout = d1_dout;
                break;
            end
        end
        req = 1'b0;
        @(posedge clk); @(negedge clk);
        n_resp = d1_ack | d1_err;
        n_dout = d1_dout;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b1; wr = 1'b1; be = 4'hF; addr = 32'h1004; wdata = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        n_cmp++; if ({d1_ack, d1_err} !== 2'b00) begin n_bad++; $display("FAIL reset_d1_resp got=%b want=00", {d1_ack, d1_err}); end
        n_cmp++; if (d1_dout !== 32'h0) begin n_bad++; $display("FAIL reset_d1_dout got=%h want=0", d1_dout); end
        n_cmp++; if ({d0_ack, d0_err, d15_ack, d15_err} !== 4'b0000) begin n_bad++; $display("FAIL reset_other_resp got=%b want=0000", {d0_ack, d0_err, d15_ack, d15_err}); end
        n_cmp++; if ((d0_dout | d15_dout) !== 32'h0) begin n_bad++; $display("FAIL reset_other_dout got=%h want=0", d0_dout | d15_dout); end
        rst_n = 1'b1;
        access(1'b1, 4'hF, 32'h1004, 32'hDEADBEEF);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL reset_release_lat got=%0d want=2", lat); end
        n_cmp++; if (r_ack !== 1'b1) begin n_bad++; $display("FAIL reset_release_ack got=%b want=1", r_ack); end
    endtask

    task automatic test_word();
        access(1'b1, 4'hF, 32'h1004, 32'hDEADBEEF);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL word_st_lat got=%0d want=2", lat); end
        n_cmp++; if ({r_ack, r_err} !== 2'b10) begin n_bad++; $display("FAIL word_st_resp got=%b want=10", {r_ack, r_err}); end
        n_cmp++; if (r_dout !== 32'h0) begin n_bad++; $display("FAIL word_st_dout got=%h want=0", r_dout); end
        n_cmp++; if (n_resp !== 1'b0) begin n_bad++; $display("FAIL word_st_one_cycle got=%b want=0", n_resp); end
        access(1'b0, 4'hF, 32'h1004, 32'h0);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL word_ld_lat got=%0d want=2", lat); end
        n_cmp++; if (r_dout !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_ld_data got=%h want=deadbeef", r_dout); end
        n_cmp++; if (n_dout !== 32'h0) begin n_bad++; $display("FAIL word_ld_after got=%h want=0", n_dout); end
    endtask

    task automatic test_byte_merge();
        access(1'b1, 4'b0100, 32'h1006, 32'h00AA0000);
        n_cmp++; if ({r_ack, r_err} !== 2'b10) begin n_bad++; $display("FAIL merge_st_resp got=%b want=10", {r_ack, r_err}); end
        access(1'b0, 4'hF, 32'h1004, 32'h0);
        n_cmp++; if (r_dout !== 32'hDEAABEEF) begin n_bad++; $display("FAIL merge_ld_data got=%h want=deaabeef", r_dout); end
    endtask

    task automatic test_rejects();
        access(1'b0, 4'hF, 32'h1400, 32'h0);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rej_hi_lat got=%0d want=2", lat); end
        n_cmp++; if ({r_ack, r_err} !== 2'b01) begin n_bad++; $display("FAIL rej_hi_resp got=%b want=01", {r_ack, r_err}); end
        n_cmp++; if (r_dout !== 32'h0) begin n_bad++; $display("FAIL rej_hi_dout got=%h want=0", r_dout); end
        access(1'b1, 4'hF, 32'h1000, 32'h12345678);
        access(1'b1, 4'hF, 32'h0FFC, 32'hBAD0BAD0);
        n_cmp++; if ({r_ack, r_err} !== 2'b01) begin n_bad++; $display("FAIL rej_lo_resp got=%b want=01", {r_ack, r_err}); end
        access(1'b1, 4'h0, 32'h1000, 32'hBAD1BAD1);
        n_cmp++; if ({r_ack, r_err} !== 2'b01) begin n_bad++; $display("FAIL rej_be0_resp got=%b want=01", {r_ack, r_err}); end
        access(1'b0, 4'hF, 32'h1000, 32'h0);
        n_cmp++; if (r_dout !== 32'h12345678) begin n_bad++; $display("FAIL rej_mem_kept got=%h want=12345678", r_dout); end
        access(1'b1, 4'hF, 32'h13FC, 32'hCAFEF00D);
        n_cmp++; if ({r_ack, r_err} !== 2'b10) begin n_bad++; $display("FAIL last_word_st got=%b want=10", {r_ack, r_err}); end
        access(1'b0, 4'hF, 32'h13FC, 32'h0);
        n_cmp++; if (r_dout !== 32'hCAFEF00D) begin n_bad++; $display("FAIL last_word_ld got=%h want=cafef00d", r_dout); end
    endtask

    task automatic test_back_to_back();
        int t1[4], t0[4], t15[4];
        int c1, c0, c15, errs;
        int e1[4], e0[4], e15[4];
        e1  = '{2, 5, 8, 11};
        e0  = '{1, 3, 5, 7};
        e15 = '{16, 33, 50, 67};
        c1 = 0; c0 = 0; c15 = 0; errs = 0;
        for (int i = 0; i < 4; i++) begin t1[i] = -1; t0[i] = -1; t15[i] = -1; end
        rst_n = 1'b0; req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        req = 1'b1; wr = 1'b0; be = 4'hF; addr = 32'h1004; wdata = 32'h0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(posedge clk); @(negedge clk);
            if (d1_ack && c1 < 4)   begin t1[c1] = cyc;   c1++;  end
            if (d0_ack && c0 < 4)   begin t0[c0] = cyc;   c0++;  end
            if (d15_ack && c15 < 4) begin t15[c15] = cyc; c15++; end
            if (d1_err || d0_err || d15_err) errs++;
        end
        req = 1'b0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (t1[i] !== e1[i])   begin n_bad++; $display("FAIL b2b_ws1_ack%0d got=%0d want=%0d", i, t1[i], e1[i]); end
            n_cmp++; if (t0[i] !== e0[i])   begin n_bad++; $display("FAIL b2b_ws0_ack%0d got=%0d want=%0d", i, t0[i], e0[i]); end
            n_cmp++; if (t15[i] !== e15[i]) begin n_bad++; $display("FAIL b2b_ws15_ack%0d got=%0d want=%0d", i, t15[i], e15[i]); end
        end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL b2b_no_err got=%0d want=0", errs); end
    endtask

    task automatic test_abort();
        access(1'b1, 4'hF, 32'h1008, 32'h11111111);
        req = 1'b1; wr = 1'b1; be = 4'hF; addr = 32'h1008; wdata = 32'h22222222;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++; if ({d1_ack, d1_err} !== 2'b00) begin n_bad++; $display("FAIL abort_no_resp got=%b want=00", {d1_ack, d1_err}); end
        req = 1'b0; rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++; if ({d1_ack, d1_err} !== 2'b00) begin n_bad++; $display("FAIL abort_idle got=%b want=00", {d1_ack, d1_err}); end
        access(1'b0, 4'hF, 32'h1008, 32'h0);
        n_cmp++; if (r_dout !== 32'h11111111) begin n_bad++; $display("FAIL abort_mem_kept got=%h want=11111111", r_dout); end
    endtask

    task automatic test_req_drop();
        req = 1'b1; wr = 1'b1; be = 4'hF; addr = 32'h100C; wdata = 32'h33333333;
        @(posedge clk); @(negedge clk);
        req = 1'b0; wr = 1'b0; be = 4'h0; addr = 32'h1400; wdata = 32'hFFFFFFFF;
        @(posedge clk); @(negedge clk);
        n_cmp++; if ({d1_ack, d1_err} !== 2'b10) begin n_bad++; $display("FAIL drop_resp got=%b want=10", {d1_ack, d1_err}); end
        @(posedge clk); @(negedge clk);
        access(1'b0, 4'hF, 32'h100C, 32'h0);
        n_cmp++; if (r_dout !== 32'h33333333) begin n_bad++; $display("FAIL drop_written got=%h want=33333333", r_dout); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_merge();
        test_rejects();
        test_abort();
        test_req_drop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
